// File: rtl/rolling_variance_engine_if.sv
// rtl/rolling_variance_engine_if.sv - sample, flush and result signals of the rolling variance engine
interface rolling_variance_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STOCKS = 4
);
    localparam int SW = $clog2(NUM_STOCKS);

    logic                  i_valid;
    logic [SW-1:0]         i_stock_id;
    logic [DATA_WIDTH-1:0] i_best_bid;
    logic [DATA_WIDTH-1:0] i_best_ask;
    logic                  i_flush;
    logic [SW-1:0]         i_flush_stock;
    logic                  o_valid;
    logic [SW-1:0]         o_stock_id;
    logic [DATA_WIDTH-1:0] o_mean;
    logic [DATA_WIDTH-1:0] o_variance;
    logic                  o_window_full;

    modport master (
        output i_valid, i_stock_id, i_best_bid, i_best_ask, i_flush, i_flush_stock,
        input  o_valid, o_stock_id, o_mean, o_variance, o_window_full
    );

    modport slave (
        input  i_valid, i_stock_id, i_best_bid, i_best_ask, i_flush, i_flush_stock,
        output o_valid, o_stock_id, o_mean, o_variance, o_window_full
    );
endinterface

// File: rtl/rolling_variance_engine.sv
// rtl/rolling_variance_engine.sv - per-stock rolling mean/variance over a circular window of mid-prices
module rolling_variance_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int WINDOW_LOG2 = 4,
    parameter int NUM_STOCKS  = 4
) (
    input logic                      i_clk,
    input logic                      i_reset_n,
    rolling_variance_engine_if.slave bus
);
    localparam int SW   = $clog2(NUM_STOCKS);
    localparam int WIN  = 1 << WINDOW_LOG2;
    localparam int CW   = WINDOW_LOG2 + 1;
    localparam int SUMW = DATA_WIDTH + WINDOW_LOG2;
    localparam int SQW  = 2 * DATA_WIDTH + WINDOW_LOG2;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] WIN_CNT = CW'(WIN);

    // Per-channel running state
    logic [WINDOW_LOG2-1:0] ptr_q   [NUM_STOCKS];
    logic [CW-1:0]          cnt_q   [NUM_STOCKS];
    logic [SUMW-1:0]        sum_q   [NUM_STOCKS];
    logic [SQW-1:0]         sumsq_q [NUM_STOCKS];

    // Sample window storage, {stock, ptr} addressed, registered read
    logic [DATA_WIDTH-1:0] mem [NUM_STOCKS * WIN];
    logic [DATA_WIDTH-1:0] rd_q;

    // Stage 1 -> 2
    logic                   s1_valid_q;
    logic [SW-1:0]          s1_stock_q;
    logic [DATA_WIDTH-1:0]  s1_mid_q, s1_mid_d;
    logic [WINDOW_LOG2-1:0] s1_ptr_q, s1_ptr_d;
    logic [CW-1:0]          s1_cnt_q, s1_cnt_d;
    logic                   s1_commit;
    logic [CW-1:0]          cnt_inc;
    logic [DATA_WIDTH:0]    mid_wide;

    // Stage 2 -> 3
    logic                   s2_valid_q;
    logic [SW-1:0]          s2_stock_q;
    logic [SUMW-1:0]        s2_sum_q, s2_sum_d;
    logic [SQW-1:0]         s2_sumsq_q, s2_sumsq_d;
    logic                   s2_full_q, s2_full_d;
    logic [DATA_WIDTH-1:0]  evict;
    logic [PW-1:0]          mid_sq, evict_sq;

    // Stage 3 -> outputs
    logic [DATA_WIDTH-1:0]  mean_d, var_d;
    logic [PW-1:0]          ex2, mean_sq, vshift;
    logic [PW:0]            diff;
    logic                   o_valid_q, o_full_q;
    logic [SW-1:0]          o_stock_q;
    logic [DATA_WIDTH-1:0]  o_mean_q, o_var_q;

    // Stage 1: mid-price and evict-slot pointer, forwarding the stage-2 sample's pointer/count advance
    always_comb begin
        mid_wide  = {1'b0, bus.i_best_bid} + {1'b0, bus.i_best_ask};
        s1_mid_d  = DATA_WIDTH'(mid_wide >> 1);
        s1_commit = s1_valid_q && !(bus.i_flush && (bus.i_flush_stock == s1_stock_q));
        cnt_inc   = (s1_cnt_q == WIN_CNT) ? s1_cnt_q : s1_cnt_q + CW'(1);
        s1_ptr_d  = ptr_q[bus.i_stock_id];
        s1_cnt_d  = cnt_q[bus.i_stock_id];
        if (bus.i_flush && (bus.i_flush_stock == bus.i_stock_id)) begin
            s1_ptr_d = '0;
            s1_cnt_d = '0;
        end else if (s1_commit && (s1_stock_q == bus.i_stock_id)) begin
            s1_ptr_d = s1_ptr_q + WINDOW_LOG2'(1);
            s1_cnt_d = cnt_inc;
        end
    end

    // Stage 2: incremental sum/sum-of-squares; evict only once the window has filled
    always_comb begin
        evict      = (s1_cnt_q == WIN_CNT) ? rd_q : '0;
        mid_sq     = {{DATA_WIDTH{1'b0}}, s1_mid_q} * {{DATA_WIDTH{1'b0}}, s1_mid_q};
        evict_sq   = {{DATA_WIDTH{1'b0}}, evict} * {{DATA_WIDTH{1'b0}}, evict};
        s2_sum_d   = sum_q[s1_stock_q] + SUMW'(s1_mid_q) - SUMW'(evict);
        s2_sumsq_d = sumsq_q[s1_stock_q] + SQW'(mid_sq) - SQW'(evict_sq);
        s2_full_d  = (cnt_inc == WIN_CNT);
    end

    // Stage 3: mean and E[x^2] - mean^2, clamped at zero and saturated at the top
    always_comb begin
        mean_d  = DATA_WIDTH'(s2_sum_q >> WINDOW_LOG2);
        ex2     = PW'(s2_sumsq_q >> WINDOW_LOG2);
        mean_sq = {{DATA_WIDTH{1'b0}}, mean_d} * {{DATA_WIDTH{1'b0}}, mean_d};
        diff    = {1'b0, ex2} - {1'b0, mean_sq};
        vshift  = diff[PW-1:0] >> FRAC_BITS;
        var_d   = vshift[DATA_WIDTH-1:0];
        if (diff[PW]) begin
            var_d = '0;
        end else if (|vshift[PW-1:DATA_WIDTH]) begin
            var_d = '1;
        end
    end

    // Pipeline registers between stages
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            s1_valid_q <= 1'b0;
            s1_stock_q <= '0;
            s1_mid_q   <= '0;
            s1_ptr_q   <= '0;
            s1_cnt_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_stock_q <= '0;
            s2_sum_q   <= '0;
            s2_sumsq_q <= '0;
            s2_full_q  <= 1'b0;
        end else begin
            s1_valid_q <= bus.i_valid;
            s1_stock_q <= bus.i_stock_id;
            s1_mid_q   <= s1_mid_d;
            s1_ptr_q   <= s1_ptr_d;
            s1_cnt_q   <= s1_cnt_d;
            s2_valid_q <= s1_valid_q;
            s2_stock_q <= s1_stock_q;
            s2_sum_q   <= s2_sum_d;
            s2_sumsq_q <= s2_sumsq_d;
            s2_full_q  <= s2_full_d;
        end
    end

    // Channel state commit; a flush is applied last so it overrides a same-stock update
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                ptr_q[i]   <= '0;
                cnt_q[i]   <= '0;
                sum_q[i]   <= '0;
                sumsq_q[i] <= '0;
            end
        end else begin
            if (s1_commit) begin
                ptr_q[s1_stock_q]   <= s1_ptr_q + WINDOW_LOG2'(1);
                cnt_q[s1_stock_q]   <= cnt_inc;
                sum_q[s1_stock_q]   <= s2_sum_d;
                sumsq_q[s1_stock_q] <= s2_sumsq_d;
            end
            if (bus.i_flush) begin
                ptr_q[bus.i_flush_stock]   <= '0;
                cnt_q[bus.i_flush_stock]   <= '0;
                sum_q[bus.i_flush_stock]   <= '0;
                sumsq_q[bus.i_flush_stock] <= '0;
            end
        end
    end

    // Window RAM: stage-2 write of the new mid, stage-1 read of the slot it will evict
    always_ff @(posedge i_clk) begin
        if (i_reset_n && s1_commit) begin
            mem[{s1_stock_q, s1_ptr_q}] <= s1_mid_q;
        end
        rd_q <= mem[{bus.i_stock_id, s1_ptr_d}];
    end

    // Result registers hold their value between strobes
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_valid_q <= 1'b0;
            o_stock_q <= '0;
            o_mean_q  <= '0;
            o_var_q   <= '0;
            o_full_q  <= 1'b0;
        end else begin
            o_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                o_stock_q <= s2_stock_q;
                o_mean_q  <= mean_d;
                o_var_q   <= var_d;
                o_full_q  <= s2_full_q;
            end
        end
    end

    assign bus.o_valid       = o_valid_q;
    assign bus.o_stock_id    = o_stock_q;
    assign bus.o_mean        = o_mean_q;
    assign bus.o_variance    = o_var_q;
    assign bus.o_window_full = o_full_q;
endmodule

// File: doc/rolling_variance_engine.md
# rolling_variance_engine

Multi-stock rolling mean/variance engine feeding the spread and reference-price calculators. Each accepted top-of-book update produces a fixed-point mid-price. The mid is pushed into that stock's circular window of 2^WINDOW_LOG2 samples. Running sum and sum-of-squares are updated incrementally, and mean and variance (E[x²] − E[x]²) are emitted for that stock three cycles later.

## Interface
- DATA_WIDTH, 32, price/output width (unsigned fixed point)
- FRAC_BITS, 16, fractional bits of prices, mean and variance (Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS)
- WINDOW_LOG2, 4, log2 of window depth; legal range 1..8 (window 2..256)
- NUM_STOCKS, 4, independent channels; ≥2
- i_clk  in  1  clock
- i_reset_n  in  1  reset i_reset_n, synchronous, active-low; clock i_clk
- i_valid  in  1  sample strobe; accepted every cycle (no backpressure)
- i_stock_id  in  $clog2(NUM_STOCKS)  channel of sample
- i_best_bid  in  DATA_WIDTH  best bid, fixed point
- i_best_ask  in  DATA_WIDTH  best ask, fixed point
- i_flush  in  1  clear the window of i_flush_stock
- i_flush_stock  in  $clog2(NUM_STOCKS)  channel to flush
- o_valid  out  1  result strobe, one per accepted sample
- o_stock_id  out  $clog2(NUM_STOCKS)  channel of result
- o_mean  out  DATA_WIDTH  sum >> WINDOW_LOG2
- o_variance  out  DATA_WIDTH  variance, same Q format, saturated
- o_window_full  out  1  channel count reached window depth at this sample

## Operation
- Mid-price: (bid + ask) >> 1, computed at DATA_WIDTH+1 bits so there is no overflow, then truncated.
- Per-channel state:
  - write pointer, WINDOW_LOG2 bits, wraps naturally;
  - fill count, 0..2^WINDOW_LOG2, saturating;
  - sum, DATA_WIDTH+WINDOW_LOG2 bits;
  - sum of squares, 2·DATA_WIDTH+WINDOW_LOG2 bits, holding full-precision squares with 2·FRAC_BITS fraction.
- Sample storage: NUM_STOCKS·2^WINDOW_LOG2 words, addressed {stock, ptr}, with registered read (RAM-inferable). Storage is not cleared by reset.
- Evicted value: the word at {stock, ptr} if count == window, else 0. Stale RAM contents therefore never enter the statistics.
- Update: sum += mid − evict; sumsq += mid² − evict²; store mid at ptr; ptr++; count++ (saturating).
- Divisor is always the full window, including during warm-up. o_window_full flags trustworthy results.
- Variance:
  - ex2 = sumsq >> WINDOW_LOG2;
  - m = sum >> WINDOW_LOG2;
  - v = ex2 − m²;
  - if v < 0 (truncation artefact), output 0;
  - otherwise v >> FRAC_BITS, saturated to all-ones if it exceeds DATA_WIDTH bits.
- Flush: zeroes the channel's count, sum, sumsq and ptr at the end of the cycle.
  - Same-cycle flush and valid on the same stock: flush applies first, and the sample becomes the channel's first sample (count=1).
  - Flush of stock A alongside a valid for stock B: both take effect.
  - A flush landing while a sample of the same stock is in flight in stages 1–2: the flush wins. That sample's state update is discarded; its output is still emitted, computed from the pre-flush state.
- Reset: clears all pointers, counts, sums and the pipeline valids. All outputs are 0 during reset and on the first cycle after it.

## Timing
- Stage 1 (cycle t): capture the sample, compute mid, issue the RAM read of the evict slot.
- Stage 2 (t+1):
  - update sum/sumsq registers;
  - write the RAM;
  - advance ptr/count.
- Stage 3 (t+2): register the mean/variance computation. o_valid is high in cycle t+3, i.e. the first edge after stage 3.
- Latency is 3 cycles and throughput is 1 sample/cycle, with any stock sequence including back-to-back same stock.
- Same-stock back-to-back samples:
  - stage 2 reads sums already updated by the previous sample, so no forwarding is needed;
  - the evict slots differ because WINDOW ≥ 2, so there is no RAM read/write collision.
- Outputs hold their last value while o_valid is low.
- o_valid is a single-cycle pulse per sample; there is no output stall.

## Test plan
- Reset: hold i_reset_n=0 with i_valid=1 for 3 cycles -> o_valid=0, o_mean=0, o_variance=0 throughout and for 3 cycles after release; no state change.
- Warm-up/steady (defaults): 16 samples on stock 0 with bid=ask=0x0064_0000 (100.0) ->
  - first result: o_mean=0x0006_4000 (6.25), o_window_full=0;
  - 16th result: o_mean=0x0064_0000, o_variance=0, o_window_full=1.
- Variance (WINDOW_LOG2=2): mids 1.0, 3.0, 1.0, 3.0 on stock 1 -> 4th result o_mean=0x0002_0000, o_variance=0x0001_0000.
  - A 5th sample of 3.0 evicts 1.0 -> o_mean=0x0002_8000, o_variance=0x0000_C000.
- Interleaving: back-to-back samples alternating stocks 0/1/2/3 every cycle -> each channel's results match an independent reference model; o_stock_id matches the input order at 3-cycle latency.
- Flush collision: i_flush=1 on stock 2 in the same cycle as i_valid on stock 2 (mid 5.0), with the window previously full -> result o_mean=0x0000_5000 (5.0/16), o_window_full=0.
- Reset mid-stream: assert reset while 2 samples are in flight -> neither emits o_valid. The next sample after release behaves as count=1, ignoring stale RAM contents.
